// File: rtl/modulate_engine.sv
// modulate_engine: pipelined PASS/AM/FM/PM modulator with shadowed config and a muted, flushed mode-switch sequence.
// Build option: define MODULATE_ENGINE_PM_EN to enable PM (mode 3); otherwise mode 3 is treated as PASS.
module modulate_engine #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int PHASE_WIDTH  = 32,
  parameter int ROM_LAT      = 2
) (
  input  logic                                clk_in,
  input  logic                                RST,
  input  logic                                src_sel,
  input  logic [1:0]                          mode_req,
  input  logic                                cfg_load,
  input  logic [PHASE_WIDTH-1:0]              cfg_center_fre,
  input  logic [PHASE_WIDTH-INPUT_WIDTH-1:0]  cfg_move_fre,
  input  logic [15:0]                         cfg_module_deep,
  input  logic [INPUT_WIDTH-1:0]              Inside_Wave,
  input  logic [INPUT_WIDTH-1:0]              Outside_Wave,
  output logic [PHASE_WIDTH-1:0]              rom_phase,
  input  logic [OUTPUT_WIDTH-1:0]             rom_data,
  output logic [OUTPUT_WIDTH-1:0]             wave_out,
  output logic                                wave_valid,
  output logic                                busy,
  output logic [1:0]                          mode_cur
);
  localparam int IW = INPUT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam int MW = OW + 2;
  localparam int L  = ROM_LAT + 3;
  localparam int CW = $clog2(L);
  localparam logic [IW-1:0] MID_IW = {1'b1, {(IW-1){1'b0}}};
  localparam logic [OW-1:0] MID    = {1'b1, {(OW-1){1'b0}}};
  localparam logic [1:0] M_PASS = 2'd0, M_AM = 2'd1, M_FM = 2'd2, M_PM = 2'd3;

  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_SWITCH} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d, req_mode;
  logic                 flush, load_ok;
  logic [PW-1:0]        cen_q, cen_d;
  logic [PW-IW-1:0]     move_q, move_d;
  logic [15:0]          deep_q, deep_d;
  logic [PW-1:0]        acc_q, acc_d, s_ext, fm_term;
  logic [IW-1:0]        wave_sel, cap_q, cap_d;
  logic [IW-1:0]        dly_q [ROM_LAT];
  logic [IW-1:0]        dly_d [ROM_LAT];
  logic signed [IW-1:0] s_now, s_m;
  logic signed [OW-1:0] c_m;
  logic signed [IW+16:0] sd;
  logic signed [17:0]   g;
  logic signed [OW+17:0] cg;
  logic signed [MW-1:0] mult_q, mult_d, sum;
  logic [OW-1:0]        pass_q, pass_d, out_q, out_d;

`ifdef MODULATE_ENGINE_PM_EN
  assign req_mode  = mode_req;
  assign rom_phase = (mode_q == M_PM) ? acc_q + {cap_q ^ MID_IW, {(PW-IW){1'b0}}} : acc_q;
`else
  assign req_mode  = (mode_req == M_PM) ? M_PASS : mode_req;
  assign rom_phase = acc_q;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    flush   = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (cnt_q == CW'(L-1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN:    if (req_mode != mode_q) state_d = ST_SWITCH;
      ST_SWITCH: begin
        mode_d  = req_mode;
        flush   = 1'b1;
        cnt_d   = '0;
        state_d = ST_FILL;
      end
      default:   state_d = ST_FILL;
    endcase
  end

  // Loads while busy are dropped; a RUN load feeds the accumulator on the same edge it commits.
  always_comb begin
    load_ok = cfg_load && (state_q == ST_RUN);
    cen_d   = load_ok ? cfg_center_fre  : cen_q;
    move_d  = load_ok ? cfg_move_fre    : move_q;
    deep_d  = load_ok ? cfg_module_deep : deep_q;
  end

  // Capture edge: the selected wave is latched and also steps the accumulator.
  always_comb begin
    wave_sel = src_sel ? Outside_Wave : Inside_Wave;
    s_now    = $signed(wave_sel ^ MID_IW);
    s_ext    = PW'(s_now);
    fm_term  = '0;
    if (mode_q == M_FM) fm_term = s_ext * {{IW{1'b0}}, move_d};
    acc_d    = flush ? '0 : acc_q + cen_d + fm_term;
    cap_d    = flush ? MID_IW : wave_sel;
    dly_d[0] = flush ? MID_IW : cap_q;
    for (int i = 1; i < ROM_LAT; i++) dly_d[i] = flush ? MID_IW : dly_q[i-1];
  end

  // Multiply stage lines up with the returning ROM sample; the delayed wave supplies AM gain and PASS data.
  always_comb begin
    s_m    = $signed(dly_q[ROM_LAT-1] ^ MID_IW);
    c_m    = $signed(rom_data ^ MID);
    sd     = s_m * $signed({1'b0, deep_q});
    g      = 18'sd65536;
    if (mode_q == M_AM) g = 18'sd65536 + 18'(sd >>> (IW-1));
    cg     = c_m * g;
    mult_d = flush ? '0 : MW'(cg >>> 16);
    pass_d = flush ? MID : OW'({dly_q[ROM_LAT-1], {OW{1'b0}}} >> IW);
  end

  always_comb begin
    sum = mult_q + $signed({2'b00, MID});
    if (flush)                 out_d = MID;
    else if (mode_q == M_PASS) out_d = pass_q;
    else if (sum[MW-1])        out_d = '0;
    else if (sum[OW])          out_d = '1;
    else                       out_d = sum[OW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only; the short delay line is reset like any other flop.
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      mode_q  <= M_PASS;
      cen_q   <= '0;
      move_q  <= '0;
      deep_q  <= '0;
      acc_q   <= '0;
      cap_q   <= MID_IW;
      for (int i = 0; i < ROM_LAT; i++) dly_q[i] <= MID_IW;
      mult_q  <= '0;
      pass_q  <= MID;
      out_q   <= MID;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cen_q   <= cen_d;
      move_q  <= move_d;
      deep_q  <= deep_d;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      dly_q   <= dly_d;
      mult_q  <= mult_d;
      pass_q  <= pass_d;
      out_q   <= out_d;
    end
  end

  assign wave_valid = (state_q == ST_RUN);
  assign busy       = ~wave_valid;
  assign wave_out   = wave_valid ? out_q : MID;
  assign mode_cur   = mode_q;
endmodule

// File: tb/tb_modulate_engine.sv
// Directed bench for modulate_engine: stimulus pushes expected wave_out samples into a scoreboard
// that a negedge monitor pops; control/phase behaviour is checked inline.
module tb_modulate_engine;
  logic        clk_in = 1'b0;
  logic        RST = 1'b1;
  logic        src_sel = 1'b0;
  logic [1:0]  mode_req = 2'd0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_center_fre = '0;
  logic [19:0] cfg_move_fre = '0;
  logic [15:0] cfg_module_deep = '0;
  logic [11:0] Inside_Wave = 12'hABC;
  logic [11:0] Outside_Wave = 12'h000;
  logic [11:0] rom_data = 12'h800;
  logic [31:0] rom_phase;
  logic [11:0] wave_out;
  logic        wave_valid, busy;
  logic [1:0]  mode_cur;

  modulate_engine dut (
    .clk_in(clk_in), .RST(RST), .src_sel(src_sel), .mode_req(mode_req), .cfg_load(cfg_load),
    .cfg_center_fre(cfg_center_fre), .cfg_move_fre(cfg_move_fre), .cfg_module_deep(cfg_module_deep),
    .Inside_Wave(Inside_Wave), .Outside_Wave(Outside_Wave), .rom_phase(rom_phase), .rom_data(rom_data),
    .wave_out(wave_out), .wave_valid(wave_valid), .busy(busy), .mode_cur(mode_cur)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          cyc;
    logic [11:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input string name, input int c, input logic [11:0] v);
    exp_t e;
    e.cyc = c; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL %s: expected sample 0x%0h at cycle %0d never checked", sb[0].name, sb[0].val, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, " valid"}, 32'(wave_valid), 32'd1);
      check(e.name, 32'(wave_out), 32'(e.val));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_run(input string name);
    int k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    check({name, " reached RUN"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " wave_out"}, 32'(wave_out), 32'h800);
    check({name, " rom_phase"}, rom_phase, 32'h0);
    check({name, " valid"}, 32'(wave_valid), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd1);
    check({name, " mode_cur"}, 32'(mode_cur), 32'd0);
  endtask

  logic [15:0] am_deep [5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF};
  logic [11:0] am_wave [5] = '{12'h000, 12'hFFF, 12'hC00, 12'hC00, 12'hFFF};
  logic [11:0] am_rom  [5] = '{12'hFFF, 12'hFFF, 12'hC00, 12'h400, 12'h000};
  logic [11:0] am_exp  [5] = '{12'h800, 12'hFFF, 12'hD00, 12'h300, 12'h000};

  initial begin
    int base;
    logic [31:0] p0;
    #1 RST = 1'b0;
    #2 check_reset_outputs("reset");

    // Release reset in PASS: five FILL cycles, then the held wave comes out
    step(2);
    RST  = 1'b1;
    base = cyc;
    expect_out("pass first", base + 5, 12'hABC);
    for (int i = 0; i < 4; i++) begin
      step();
      check("fill busy", 32'(busy), 32'd1);
      check("fill wave_out mid", 32'(wave_out), 32'h800);
    end
    step();
    check("run busy", 32'(busy), 32'd0);
    check("run valid", 32'(wave_valid), 32'd1);
    check("pass rom_phase zero cfg", rom_phase, 32'h0);

    // PASS latency and source select
    base = cyc;
    Inside_Wave  = 12'h123;
    expect_out("pass old", base + 4, 12'hABC);
    expect_out("pass latency", base + 5, 12'h123);
    step();
    Outside_Wave = 12'h5E7;
    src_sel      = 1'b1;
    expect_out("src outside", base + 6, 12'h5E7);
    step(6);
    src_sel = 1'b0;

    // FM: config load and mode change in the same RUN cycle
    cfg_center_fre = 32'h0100_0000;
    cfg_move_fre   = 20'h100;
    cfg_load       = 1'b1;
    mode_req       = 2'd2;
    Inside_Wave    = 12'hA00;
    step();
    cfg_load = 1'b0;
    check("switch busy", 32'(busy), 32'd1);
    wait_run("fm");
    check("fm mode_cur", 32'(mode_cur), 32'd2);
    p0 = rom_phase; step();
    check("fm step +512", rom_phase - p0, 32'h0102_0000);
    p0 = rom_phase; step();
    check("fm step +512 again", rom_phase - p0, 32'h0102_0000);
    Inside_Wave = 12'h800;
    step(2);
    p0 = rom_phase; step();
    check("fm step zero", rom_phase - p0, 32'h0100_0000);
    Inside_Wave = 12'h600;
    step(2);
    p0 = rom_phase; step();
    check("fm step -512", rom_phase - p0, 32'h00FE_0000);

    // Switch FM->AM with a load pulsed during FILL, which must be dropped
    base = cyc;
    mode_req = 2'd1;
    step();
    check("sw c1 busy", 32'(busy), 32'd1);
    check("sw c1 valid", 32'(wave_valid), 32'd0);
    step();
    check("sw c2 busy", 32'(busy), 32'd1);
    check("acc restart", rom_phase, 32'h0);
    check("sw mode_cur", 32'(mode_cur), 32'd1);
    cfg_center_fre = 32'h0010_0000;
    cfg_load       = 1'b1;
    step();
    cfg_load = 1'b0;
    check("acc first step", rom_phase, 32'h0100_0000);
    check("sw c3 busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sw fill busy", 32'(busy), 32'd1);
      check("sw fill valid", 32'(wave_valid), 32'd0);
    end
    step();
    check("sw done busy", 32'(busy), 32'd0);
    check("sw done cycles", 32'(cyc - base), 32'd7);
    p0 = rom_phase; step();
    check("dropped load step", rom_phase - p0, 32'h0100_0000);
    cfg_center_fre = 32'h0100_0000;

    // AM gain and saturation
    for (int i = 0; i < 5; i++) begin
      cfg_module_deep = am_deep[i];
      Inside_Wave     = am_wave[i];
      rom_data        = am_rom[i];
      cfg_load        = 1'b1;
      expect_out($sformatf("am vec%0d", i), cyc + 5, am_exp[i]);
      step();
      cfg_load = 1'b0;
      step(5);
    end

    // AM with zero depth: output is rom_data two cycles later
    cfg_module_deep = 16'h0000;
    cfg_load        = 1'b1;
    step();
    cfg_load = 1'b0;
    step(6);
    for (int i = 0; i < 10; i++) begin
      rom_data    = 12'(i * 679 + 21);
      Inside_Wave = 12'(i * 1301 + 7);
      expect_out($sformatf("am deep0 %0d", i), cyc + 2, rom_data);
      step();
    end
    step(3);

    // Reset during FILL, then request mode 3
    mode_req = 2'd0;
    step(3);
    check("pre-reset busy", 32'(busy), 32'd1);
    RST = 1'b0;
    #1 check_reset_outputs("mid reset");
    mode_req    = 2'd3;
    Inside_Wave = 12'h5A5;
    step(2);
    RST = 1'b1;
    expect_out("post reset pass", cyc + 5, 12'h5A5);
    wait_run("post reset");
    check("post reset rom_phase", rom_phase, 32'h0);
`ifdef MODULATE_ENGINE_PM_EN
    step();
    check("pm switch busy", 32'(busy), 32'd1);
    wait_run("pm");
    check("pm mode_cur", 32'(mode_cur), 32'd3);
`else
    check("mode3 mode_cur", 32'(mode_cur), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mode3 stays run", 32'(busy), 32'd0);
    end
`endif
    step(3);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
